// File: rtl/dcm_phaseshift_multich_if.sv
// Phase-shift controller bus: register-side request/status plus the per-DCM PSEN/PSINCDEC/PSDONE handshake.
// The controller uses the master modport; the host/DCM side uses slave.
interface dcm_phaseshift_multich_if #(
   parameter int NUM_CH  = 2,
   parameter int PHASE_W = 9
);
   logic [NUM_CH*PHASE_W-1:0] value_i;
   logic [NUM_CH-1:0]         load_i;
   logic [NUM_CH*PHASE_W-1:0] value_o;
   logic [NUM_CH-1:0]         done_o;
   logic                      busy_o;
   logic [NUM_CH-1:0]         err_o;
   logic [NUM_CH-1:0]         dcm_psen_o;
   logic [NUM_CH-1:0]         dcm_psincdec_o;
   logic [NUM_CH-1:0]         dcm_psdone_i;
   logic [NUM_CH-1:0]         dcm_locked_i;
   logic [NUM_CH-1:0]         dcm_ovf_i;

   modport master (
      input  value_i, load_i, dcm_psdone_i, dcm_locked_i, dcm_ovf_i,
      output value_o, done_o, busy_o, err_o, dcm_psen_o, dcm_psincdec_o
   );

   modport slave (
      output value_i, load_i, dcm_psdone_i, dcm_locked_i, dcm_ovf_i,
      input  value_o, done_o, busy_o, err_o, dcm_psen_o, dcm_psincdec_o
   );
endinterface

// File: rtl/dcm_phaseshift_multich.sv
// Round-robin variable phase-shift stepper for NUM_CH DCMs, one tap per grant.
// Define PS_TIMEOUT_EN to bound the wait for PSDONE with a TIMEOUT-cycle counter.
module dcm_phaseshift_multich #(
   parameter int NUM_CH   = 2,
   parameter int PHASE_W  = 9,
   parameter int PS_LIMIT = 255,
   parameter int TIMEOUT  = 255
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   dcm_phaseshift_multich_if.master bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic signed [PHASE_W-1:0] LIM_POS = PHASE_W'(PS_LIMIT);
   localparam logic signed [PHASE_W-1:0] LIM_NEG = -LIM_POS;

   typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_PULSE, ST_WAIT} state_t;

   state_t                    state_q, state_d;
   logic signed [PHASE_W-1:0] target_q [NUM_CH];
   logic signed [PHASE_W-1:0] target_d [NUM_CH];
   logic signed [PHASE_W-1:0] actual_q [NUM_CH];
   logic signed [PHASE_W-1:0] actual_d [NUM_CH];
   logic signed [PHASE_W-1:0] req_clamped [NUM_CH];
   logic [CH_W-1:0]           grant_q, grant_d;
   logic [CH_W-1:0]           rr_q, rr_d;
   logic                      dir_q, dir_d;
   logic [NUM_CH-1:0]         err_q, err_d;
   logic [NUM_CH-1:0]         eligible;
   logic [NUM_CH-1:0]         in_flight;
   logic                      pulse_dir;
   logic                      sel_found, hi_found;
   logic [CH_W-1:0]           sel_ch, hi_ch, lo_ch;
   logic                      step_end;
   logic                      any_next;
`ifdef PS_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
`endif

   // Direction is taken live during PULSE and frozen into dir_q for the rest of the step.
   assign pulse_dir   = (target_q[grant_q] > actual_q[grant_q]);
   assign bus.busy_o  = (state_q != ST_IDLE);
   assign bus.err_o   = err_q;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic signed [PHASE_W-1:0] req;
      assign req = bus.value_i[gi*PHASE_W +: PHASE_W];
      assign req_clamped[gi] = (req > LIM_POS) ? LIM_POS : ((req < LIM_NEG) ? LIM_NEG : req);
      assign eligible[gi]    = bus.dcm_locked_i[gi] & (target_q[gi] != actual_q[gi]);
      assign in_flight[gi]   = ((state_q == ST_PULSE) || (state_q == ST_WAIT)) && (grant_q == CH_W'(gi));
      assign bus.value_o[gi*PHASE_W +: PHASE_W] = actual_q[gi];
      assign bus.done_o[gi]  = (actual_q[gi] == target_q[gi]) & ~in_flight[gi];
      assign bus.dcm_psen_o[gi] = (state_q == ST_PULSE) && (grant_q == CH_W'(gi)) && !reset_i;
      assign bus.dcm_psincdec_o[gi] = in_flight[gi] && !reset_i &&
                                      ((state_q == ST_PULSE) ? pulse_dir : dir_q);
   end

   // Lowest eligible channel at/after rr_q wins; otherwise wrap to the lowest eligible overall.
   always_comb begin
      hi_found  = 1'b0;
      sel_found = 1'b0;
      hi_ch     = '0;
      lo_ch     = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (eligible[k]) begin
            lo_ch     = CH_W'(k);
            sel_found = 1'b1;
            if (k >= int'(rr_q)) begin
               hi_ch    = CH_W'(k);
               hi_found = 1'b1;
            end
         end
      end
      sel_ch = hi_found ? hi_ch : lo_ch;
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_d     = rr_q;
      dir_d    = dir_q;
      err_d    = err_q;
      target_d = target_q;
      actual_d = actual_q;
      step_end = 1'b0;
      any_next = 1'b0;
`ifdef PS_TIMEOUT_EN
      to_cnt_d = to_cnt_q;
`endif
      // A DCM that loses lock is reset and comes back at phase 0.
      for (int i = 0; i < NUM_CH; i++) begin
         if (!bus.dcm_locked_i[i]) actual_d[i] = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (|eligible) state_d = ST_SELECT;
         end
         ST_SELECT: begin
            if (sel_found) begin
               grant_d = sel_ch;
               rr_d    = (sel_ch == CH_W'(NUM_CH - 1)) ? '0 : sel_ch + 1'b1;
               state_d = ST_PULSE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PULSE: begin
            dir_d   = pulse_dir;
            state_d = bus.dcm_locked_i[grant_q] ? ST_WAIT : ST_IDLE;
`ifdef PS_TIMEOUT_EN
            to_cnt_d = '0;
`endif
         end
         ST_WAIT: begin
            if (!bus.dcm_locked_i[grant_q]) begin
               state_d = ST_IDLE;
            end else if (bus.dcm_psdone_i[grant_q]) begin
               step_end = 1'b1;
               if (bus.dcm_ovf_i[grant_q]) begin
                  err_d[grant_q]    = 1'b1;
                  target_d[grant_q] = actual_q[grant_q];
               end else begin
                  actual_d[grant_q] = dir_q ? actual_q[grant_q] + PHASE_W'(1)
                                            : actual_q[grant_q] - PHASE_W'(1);
               end
            end
`ifdef PS_TIMEOUT_EN
            else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
               err_d[grant_q]    = 1'b1;
               target_d[grant_q] = actual_q[grant_q];
               state_d           = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      // Loads are accepted in every state and take priority over an overflow/timeout retarget.
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.load_i[i]) begin
            target_d[i] = req_clamped[i];
            err_d[i]    = 1'b0;
         end
      end

      for (int i = 0; i < NUM_CH; i++) begin
         any_next = any_next | (bus.dcm_locked_i[i] & (target_d[i] != actual_d[i]));
      end
      if (step_end) state_d = any_next ? ST_SELECT : ST_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         dir_q   <= 1'b0;
         err_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            target_q[i] <= '0;
            actual_q[i] <= '0;
         end
`ifdef PS_TIMEOUT_EN
         to_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_q     <= rr_d;
         dir_q    <= dir_d;
         err_q    <= err_d;
         target_q <= target_d;
         actual_q <= actual_d;
`ifdef PS_TIMEOUT_EN
         to_cnt_q <= to_cnt_d;
`endif
      end
   end
endmodule
